// File: rtl/ball_mover_if.sv
// Handshake between ball_mover and ball_physics: the paddle-hit request
// going out and the new trajectory coming back.
interface ball_mover_if;
  logic signed [7:0] vel_x;
  logic signed [7:0] vel_y;
  logic              vel_load;
  logic              hit_req;
  logic              hit_side;
  logic [3:0]        hit_section;

  // ball_mover side: raises the hit request, consumes the trajectory
  modport master (
    output hit_req, hit_side, hit_section,
    input  vel_x, vel_y, vel_load
  );

  // ball_physics side: answers the hit request with a new trajectory
  modport slave (
    input  hit_req, hit_side, hit_section,
    output vel_x, vel_y, vel_load
  );
endinterface

// File: rtl/ball_mover.sv
// Ball position integrator for the pong datapath. Holds the ball position and
// trajectory, advances it on frame ticks, bounces off top/bottom, requests a
// new trajectory on paddle contact and reports misses past either edge.
module ball_mover #(
  parameter int SCR_W    = 160,
  parameter int SCR_H    = 120,
  parameter int PADDLE_W = 3,
  parameter int PADDLE_H = 20,
  parameter int TICK_HZ  = 120
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable,
  input  logic         tick,
  input  logic         launch,
  input  logic [7:0]   left_paddle_pos,
  input  logic [7:0]   right_paddle_pos,
  ball_mover_if.master phys,
  output logic [7:0]   ball_x,
  output logic [6:0]   ball_y,
  output logic         miss_left,
  output logic         miss_right
);

  localparam logic [8:0] TICK9       = 9'(TICK_HZ);
  localparam logic [8:0] PH_M1       = 9'(PADDLE_H - 1);
  localparam logic [7:0] X_CENTRE    = 8'(SCR_W / 2);
  localparam logic [6:0] Y_CENTRE    = 7'(SCR_H / 2);
  localparam logic [7:0] X_MAX       = 8'(SCR_W - 1);
  localparam logic [6:0] Y_MAX       = 7'(SCR_H - 1);
  localparam logic [7:0] X_LEFT_HIT  = 8'(PADDLE_W);
  localparam logic [7:0] X_RIGHT_HIT = 8'(SCR_W - 1 - PADDLE_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_HIT
  } state_t;

  state_t            r_state, w_state;
  logic [7:0]        r_x, w_x;
  logic [6:0]        r_y, w_y;
  logic signed [7:0] r_vx, w_vx;
  logic signed [7:0] r_vy, w_vy;
  logic [8:0]        r_acc_x, w_acc_x;
  logic [8:0]        r_acc_y, w_acc_y;
  logic              r_hit_req, w_hit_req;
  logic              r_hit_side, w_hit_side;
  logic [3:0]        r_hit_sec, w_hit_sec;
  logic              r_miss_l, w_miss_l;
  logic              r_miss_r, w_miss_r;

  logic [8:0] w_abs_vx, w_abs_vy;
  logic [8:0] w_sum_x, w_sum_y;
  logic [8:0] w_acc_x_adv, w_acc_y_adv;
  logic       w_step_x, w_step_y;
  logic [8:0] w_y9, w_lp9, w_rp9;
  logic [8:0] w_ldiff, w_rdiff;
  logic       w_left_in, w_right_in;
  logic [3:0] w_left_sec, w_right_sec;

  // Per-axis rate accumulators: add |v| each tick, step when the sum reaches TICK_HZ
  always_comb begin
    w_abs_vx    = r_vx[7] ? (9'd0 - {r_vx[7], r_vx}) : {1'b0, r_vx};
    w_abs_vy    = r_vy[7] ? (9'd0 - {r_vy[7], r_vy}) : {1'b0, r_vy};
    w_sum_x     = r_acc_x + w_abs_vx;
    w_sum_y     = r_acc_y + w_abs_vy;
    w_step_x    = (r_vx != '0) && (w_sum_x >= TICK9);
    w_step_y    = (r_vy != '0) && (w_sum_y >= TICK9);
    w_acc_x_adv = w_step_x ? (w_sum_x - TICK9) : w_sum_x;
    w_acc_y_adv = w_step_y ? (w_sum_y - TICK9) : w_sum_y;
  end

  // Paddle windows on the pre-step row; 9-bit so pos+PADDLE_H-1 cannot wrap
  always_comb begin
    w_y9        = {2'b00, r_y};
    w_lp9       = {1'b0, left_paddle_pos};
    w_rp9       = {1'b0, right_paddle_pos};
    w_left_in   = (w_y9 >= w_lp9) && (w_y9 <= (w_lp9 + PH_M1));
    w_right_in  = (w_y9 >= w_rp9) && (w_y9 <= (w_rp9 + PH_M1));
    w_ldiff     = w_y9 - w_lp9;
    w_rdiff     = w_y9 - w_rp9;
    w_left_sec  = 4'(w_ldiff >> 1);
    w_right_sec = 4'(w_rdiff >> 1);
  end

  // Next-state and datapath update for IDLE / MOVE / HIT
  always_comb begin
    w_state    = r_state;
    w_x        = r_x;
    w_y        = r_y;
    w_vx       = r_vx;
    w_vy       = r_vy;
    w_acc_x    = r_acc_x;
    w_acc_y    = r_acc_y;
    w_hit_req  = r_hit_req;
    w_hit_side = r_hit_side;
    w_hit_sec  = r_hit_sec;
    w_miss_l   = 1'b0;
    w_miss_r   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (launch) begin
          w_vx    = phys.vel_x;
          w_vy    = phys.vel_y;
          w_acc_x = '0;
          w_acc_y = '0;
          w_state = S_MOVE;
        end
      end

      S_MOVE: begin
        if (tick && enable) begin
          // A suppressed edge step still consumes the accumulator crossing,
          // so the reflected ball keeps its cadence.
          w_acc_y = w_acc_y_adv;
          if (w_step_y) begin
            if (r_vy[7]) begin
              if (r_y == '0) w_vy = -r_vy;
              else           w_y  = r_y - 7'd1;
            end else begin
              if (r_y == Y_MAX) w_vy = -r_vy;
              else              w_y  = r_y + 7'd1;
            end
          end

          w_acc_x = w_acc_x_adv;
          if (w_step_x) begin
            if (r_vx[7]) begin
              if ((r_x == X_LEFT_HIT) && w_left_in) begin
                w_hit_req  = 1'b1;
                w_hit_side = 1'b0;
                w_hit_sec  = w_left_sec;
                w_state    = S_HIT;
              end else if (r_x == '0) begin
                w_miss_l = 1'b1;
              end else begin
                w_x = r_x - 8'd1;
              end
            end else begin
              if ((r_x == X_RIGHT_HIT) && w_right_in) begin
                w_hit_req  = 1'b1;
                w_hit_side = 1'b1;
                w_hit_sec  = w_right_sec;
                w_state    = S_HIT;
              end else if (r_x == X_MAX) begin
                w_miss_r = 1'b1;
              end else begin
                w_x = r_x + 8'd1;
              end
            end
          end
        end
      end

      S_HIT: begin
        // Position is frozen here; a tick arriving with vel_load is dropped.
        if (phys.vel_load) begin
          w_vx      = phys.vel_x;
          w_vy      = phys.vel_y;
          w_acc_x   = '0;
          w_acc_y   = '0;
          w_hit_req = 1'b0;
          w_state   = S_MOVE;
        end
      end

      default: w_state = S_IDLE;
    endcase

    // A miss overrides any Y movement from the same tick
    if (w_miss_l || w_miss_r) begin
      w_x     = X_CENTRE;
      w_y     = Y_CENTRE;
      w_vx    = '0;
      w_vy    = '0;
      w_acc_x = '0;
      w_acc_y = '0;
      w_state = S_IDLE;
    end
  end

  // State and datapath registers, asynchronously cleared to the centred idle ball
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_x        <= X_CENTRE;
      r_y        <= Y_CENTRE;
      r_vx       <= '0;
      r_vy       <= '0;
      r_acc_x    <= '0;
      r_acc_y    <= '0;
      r_hit_req  <= 1'b0;
      r_hit_side <= 1'b0;
      r_hit_sec  <= '0;
      r_miss_l   <= 1'b0;
      r_miss_r   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_x        <= w_x;
      r_y        <= w_y;
      r_vx       <= w_vx;
      r_vy       <= w_vy;
      r_acc_x    <= w_acc_x;
      r_acc_y    <= w_acc_y;
      r_hit_req  <= w_hit_req;
      r_hit_side <= w_hit_side;
      r_hit_sec  <= w_hit_sec;
      r_miss_l   <= w_miss_l;
      r_miss_r   <= w_miss_r;
    end
  end

  assign ball_x           = r_x;
  assign ball_y           = r_y;
  assign miss_left        = r_miss_l;
  assign miss_right       = r_miss_r;
  assign phys.hit_req     = r_hit_req;
  assign phys.hit_side    = r_hit_side;
  assign phys.hit_section = r_hit_sec;

endmodule

// File: tb/tb_ball_mover.sv
// Bench for ball_mover: launch/tick scenario table, hand sequences for the
// bounce, hit, stall, miss and reset cases, then random stimulus, all against
// a tick-count reference model (steps = floor(ticks*|v|/TICK_HZ)).
module tb_ball_mover;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int PW    = 3;
  localparam int PH    = 20;
  localparam int TICK  = 120;

  logic       clk = 1'b0;
  logic       resetn, enable, tick, launch;
  logic [7:0] lpp, rpp;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       miss_left, miss_right;

  always #5 clk = ~clk;

  ball_mover_if bif();

  ball_mover #(
    .SCR_W(SCR_W), .SCR_H(SCR_H), .PADDLE_W(PW), .PADDLE_H(PH), .TICK_HZ(TICK)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .tick(tick),
    .launch(launch),
    .left_paddle_pos(lpp),
    .right_paddle_pos(rpp),
    .phys(bif.master),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .miss_left(miss_left),
    .miss_right(miss_right)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef enum {MD_IDLE, MD_MOVE, MD_HIT} mode_t;
  mode_t m_mode;
  int m_x, m_y, m_vx, m_vy, m_n, m_sec;
  bit m_hit, m_side, m_ml, m_mr;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int nsteps(input int n, input int v);
    return (n * iabs(v)) / TICK;
  endfunction

  task automatic model_centre();
    m_x = SCR_W / 2; m_y = SCR_H / 2; m_vx = 0; m_vy = 0; m_n = 0;
    m_mode = MD_IDLE;
  endtask

  task automatic model_reset();
    model_centre();
    m_hit = 0; m_side = 0; m_sec = 0; m_ml = 0; m_mr = 0;
  endtask

  task automatic model_clk(input bit la, input bit vl, input bit tk, input bit en);
    int vxi, vyi, lp, rp, sx, sy, ypre, t;
    vxi = int'(bif.vel_x);
    vyi = int'(bif.vel_y);
    lp  = int'(lpp);
    rp  = int'(rpp);
    m_ml = 0; m_mr = 0;
    case (m_mode)
      MD_IDLE: if (la) begin
        m_vx = vxi; m_vy = vyi; m_n = 0; m_mode = MD_MOVE;
      end
      MD_MOVE: if (tk && en) begin
        sx = nsteps(m_n + 1, m_vx) - nsteps(m_n, m_vx);
        sy = nsteps(m_n + 1, m_vy) - nsteps(m_n, m_vy);
        m_n++;
        ypre = m_y;
        if (sy != 0) begin
          t = m_y + ((m_vy < 0) ? -1 : 1);
          if (t < 0 || t >= SCR_H) m_vy = -m_vy;
          else m_y = t;
        end
        if (sx != 0) begin
          if (m_vx < 0) begin
            if (m_x == PW && ypre >= lp && ypre <= lp + PH - 1) begin
              m_hit = 1; m_side = 0; m_sec = (ypre - lp) / 2; m_mode = MD_HIT;
            end else if (m_x == 0) begin
              m_ml = 1; model_centre();
            end else m_x--;
          end else begin
            if (m_x == SCR_W - 1 - PW && ypre >= rp && ypre <= rp + PH - 1) begin
              m_hit = 1; m_side = 1; m_sec = (ypre - rp) / 2; m_mode = MD_HIT;
            end else if (m_x == SCR_W - 1) begin
              m_mr = 1; model_centre();
            end else m_x++;
          end
        end
      end
      MD_HIT: if (vl) begin
        m_vx = vxi; m_vy = vyi; m_n = 0; m_hit = 0; m_mode = MD_MOVE;
      end
      default: ;
    endcase
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] act_pack();
    return {9'd0, ball_x, ball_y, bif.hit_req, bif.hit_side, bif.hit_section,
            miss_left, miss_right};
  endfunction

  function automatic logic [31:0] exp_pack();
    return {9'd0, 8'(m_x), 7'(m_y), m_hit, m_side, 4'(m_sec), m_ml, m_mr};
  endfunction

  task automatic set_vel(input int vx, input int vy);
    bif.vel_x = 8'(vx);
    bif.vel_y = 8'(vy);
  endtask

  // One clock: drive controls, let the edge pass, compare against the model
  task automatic cyc(input bit la, input bit vl, input bit tk, input bit en);
    launch = la; bif.vel_load = vl; tick = tk; enable = en;
    @(posedge clk); #1;
    model_clk(la, vl, tk, en);
    chk("cycle", act_pack(), exp_pack());
    launch = 1'b0; bif.vel_load = 1'b0; tick = 1'b0;
  endtask

  // Asynchronous reset pulse between clock edges, checked before the next edge
  task automatic do_reset();
    launch = 1'b0; bif.vel_load = 1'b0; tick = 1'b0;
    #2; resetn = 1'b0;
    #1;
    model_reset();
    chk("reset_async", act_pack(), {9'd0, 8'd80, 7'd60, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    #4; resetn = 1'b1;
  endtask

  task automatic go_left_hit(input int lp);
    do_reset();
    set_vel(-80, -16); lpp = 8'(lp); rpp = 8'd0;
    cyc(1, 0, 0, 1);
    repeat (117) cyc(0, 0, 1, 1);
  endtask

  function automatic int pad_near(input int y);
    int t;
    t = y - int'($urandom_range(0, PH - 1));
    return (t < 0) ? 0 : t;
  endfunction

  // ---------------- scenario table ----------------
  typedef struct {
    int vx, vy, ticks, lp, rp;
    bit en;
    int ex, ey;
    bit eh;
    bit es;
    int esec;
  } scen_t;

  scen_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{vx:  80, vy:   0, ticks:  60, lp:  0, rp:  0, en: 1, ex: 120, ey: 60, eh: 0, es: 0, esec: 0};
    tbl[1] = '{vx: -40, vy:   0, ticks:  30, lp:  0, rp:  0, en: 1, ex:  70, ey: 60, eh: 0, es: 0, esec: 0};
    tbl[2] = '{vx:   0, vy:  60, ticks:  40, lp:  0, rp:  0, en: 1, ex:  80, ey: 80, eh: 0, es: 0, esec: 0};
    tbl[3] = '{vx:   0, vy: -30, ticks:  80, lp:  0, rp:  0, en: 1, ex:  80, ey: 40, eh: 0, es: 0, esec: 0};
    tbl[4] = '{vx:  60, vy: -60, ticks: 100, lp:  0, rp:  0, en: 1, ex: 130, ey: 10, eh: 0, es: 0, esec: 0};
    tbl[5] = '{vx:   0, vy: -80, ticks: 150, lp:  0, rp:  0, en: 1, ex:  80, ey: 39, eh: 0, es: 0, esec: 0};
    tbl[6] = '{vx:   0, vy:  80, ticks: 120, lp:  0, rp:  0, en: 1, ex:  80, ey: 99, eh: 0, es: 0, esec: 0};
    tbl[7] = '{vx:  80, vy:   0, ticks:  60, lp:  0, rp:  0, en: 0, ex:  80, ey: 60, eh: 0, es: 0, esec: 0};
    tbl[8] = '{vx: -80, vy: -16, ticks: 117, lp: 40, rp:  0, en: 1, ex:   3, ey: 45, eh: 1, es: 0, esec: 2};
    tbl[9] = '{vx:  80, vy:  24, ticks: 116, lp:  0, rp: 70, en: 1, ex: 156, ey: 83, eh: 1, es: 1, esec: 6};

    resetn = 1'b0; enable = 1'b0; tick = 1'b0; launch = 1'b0;
    bif.vel_load = 1'b0; bif.vel_x = '0; bif.vel_y = '0;
    lpp = '0; rpp = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      do_reset();
      set_vel(tbl[i].vx, tbl[i].vy);
      lpp = 8'(tbl[i].lp); rpp = 8'(tbl[i].rp);
      cyc(1, 0, 0, tbl[i].en);
      repeat (tbl[i].ticks) cyc(0, 0, 1, tbl[i].en);
      chk($sformatf("tbl%0d_x", i), ball_x, tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), ball_y, tbl[i].ey);
      chk($sformatf("tbl%0d_hit", i), bif.hit_req, tbl[i].eh);
      chk($sformatf("tbl%0d_side", i), bif.hit_side, tbl[i].es);
      chk($sformatf("tbl%0d_sec", i), bif.hit_section, tbl[i].esec);
    end

    // Reset in the middle of MOVE
    do_reset();
    set_vel(80, 40); lpp = 8'd0; rpp = 8'd0;
    cyc(1, 0, 0, 1);
    repeat (30) cyc(0, 0, 1, 1);
    chk("midmove_x", ball_x, 100);
    chk("midmove_y", ball_y, 70);
    do_reset();

    // Top-edge bounce: y reaches 0 after 94 ticks, reflects at 96, leaves at 97
    do_reset();
    set_vel(0, -77);
    cyc(1, 0, 0, 1);
    repeat (94) cyc(0, 0, 1, 1);
    chk("bounce_at0", ball_y, 0);
    repeat (2) cyc(0, 0, 1, 1);
    chk("bounce_held", ball_y, 0);
    cyc(0, 0, 1, 1);
    chk("bounce_away", ball_y, 1);

    // Left paddle hit, launch ignored in HIT, new trajectory then first step
    go_left_hit(40);
    chk("lhit_req", bif.hit_req, 1);
    chk("lhit_side", bif.hit_side, 0);
    chk("lhit_sec", bif.hit_section, 2);
    chk("lhit_x", ball_x, 3);
    cyc(1, 0, 0, 1);
    chk("lhit_launch_ign", bif.hit_req, 1);
    set_vel(77, -22);
    cyc(0, 1, 0, 1);
    chk("lhit_load_req", bif.hit_req, 0);
    cyc(0, 0, 1, 1);
    chk("lhit_tick1_x", ball_x, 3);
    cyc(0, 0, 1, 1);
    chk("lhit_tick2_x", ball_x, 4);
    chk("lhit_tick2_y", ball_y, 45);

    // Stall in HIT for 200 ticks; vel_load with tick drops the tick
    go_left_hit(40);
    repeat (200) cyc(0, 0, 1, 1);
    chk("stall_x", ball_x, 3);
    chk("stall_y", ball_y, 45);
    chk("stall_req", bif.hit_req, 1);
    chk("stall_sec", bif.hit_section, 2);
    set_vel(80, 0);
    cyc(0, 1, 1, 1);
    chk("ldtick_req", bif.hit_req, 0);
    chk("ldtick_x", ball_x, 3);
    cyc(0, 0, 1, 1);
    chk("ldtick_t1_x", ball_x, 3);
    cyc(0, 0, 1, 1);
    chk("ldtick_t2_x", ball_x, 4);

    // Reset in the middle of HIT; hit_req stays low afterwards
    go_left_hit(40);
    do_reset();
    cyc(0, 0, 0, 1);
    chk("hitrst_req", bif.hit_req, 0);

    // Left miss: paddle out of the way, ball runs to 0 then off the edge
    go_left_hit(90);
    chk("lmiss_pass_x", ball_x, 2);
    repeat (3) cyc(0, 0, 1, 1);
    chk("lmiss_at0_x", ball_x, 0);
    cyc(0, 0, 1, 1);
    chk("lmiss_wait", miss_left, 0);
    cyc(0, 0, 1, 1);
    chk("lmiss_pulse", miss_left, 1);
    chk("lmiss_cx", ball_x, 80);
    chk("lmiss_cy", ball_y, 60);
    cyc(0, 0, 0, 1);
    chk("lmiss_width", miss_left, 0);
    repeat (5) cyc(0, 0, 1, 1);
    chk("idle_tick_x", ball_x, 80);
    set_vel(80, 0);
    cyc(0, 1, 0, 1);
    repeat (4) cyc(0, 0, 1, 1);
    chk("idle_vload_x", ball_x, 80);

    // Right miss from the centre with the right paddle parked at the top
    do_reset();
    set_vel(80, 0); rpp = 8'd0;
    cyc(1, 0, 0, 1);
    repeat (119) cyc(0, 0, 1, 1);
    chk("rmiss_at_edge", ball_x, 159);
    cyc(0, 0, 1, 1);
    chk("rmiss_pulse", miss_right, 1);
    chk("rmiss_cx", ball_x, 80);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 8000; c++) begin
      bit la, vl, tk, en;
      if ($urandom_range(0, 63) == 0)
        lpp = $urandom_range(0, 1) ? 8'(pad_near(m_y)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 63) == 0)
        rpp = $urandom_range(0, 1) ? 8'(pad_near(m_y)) : 8'($urandom_range(0, 255));
      set_vel(int'($urandom_range(0, 160)) - 80, int'($urandom_range(0, 160)) - 80);
      la = ($urandom_range(0, 7) == 0);
      vl = ($urandom_range(0, 11) == 0);
      tk = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2999) == 0) do_reset();
      cyc(la, vl, tk, en);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
